// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: 2-FF synchroniser, hold-time glitch filter, Gray-step decode
// into a one-cycle count strobe with direction, plus illegal double-step flagging.
module quad_decoder #(
  parameter int FILT_LEN = 3,
  parameter int RES      = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_i,
  input  logic b_i,
  input  logic ena_i,
  input  logic clr_err_i,
  output logic en_o,
  output logic updn_o,
  output logic err_o,
  output logic err_sticky_o
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(FILT_LEN + 2);

  logic [1:0]    sync1_q, s_ab_q, s_prev_q;
  logic [1:0]    f_ab_q, f_ab_d, f_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          init_q, init_d;
  logic          en_q, en_d, updn_q, updn_d, err_q, err_d, sticky_q, sticky_d;
  logic          step_ev;
  logic [1:0]    step_d;

  // Position along the up sequence 00 -> 10 -> 11 -> 01
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  function automatic logic res_pass(input logic [1:0] ab_new);
    if (RES == 4)      res_pass = 1'b1;
    else if (RES == 2) res_pass = (ab_new == 2'b00) || (ab_new == 2'b11);
    else               res_pass = (ab_new == 2'b00);
  endfunction

  // Filter: count consecutive cycles a differing synchronised value has held
  always_comb begin
    f_ab_d = f_ab_q;
    if (s_ab_q == f_ab_q)      cnt_d = '0;
    else if (s_ab_q != s_prev_q) cnt_d = CW'(1);
    else                       cnt_d = cnt_q + CW'(1);
    if ((s_ab_q != f_ab_q) && (cnt_d == CW'(FILT_LEN))) begin
      f_ab_d = s_ab_q;
      cnt_d  = '0;
    end
  end

  assign step_ev = (f_ab_q != f_prev_q);
  assign step_d  = gray_pos(f_ab_q) - gray_pos(f_prev_q);

  always_comb begin
    en_d   = 1'b0;
    err_d  = 1'b0;
    updn_d = updn_q;
    init_d = init_q;
    tmr_d  = (tmr_q == '0) ? '0 : tmr_q - TW'(1);
    if (step_ev) begin
      if (init_q) begin
        init_d = 1'b0;
      end else if (step_d == 2'd2) begin
        err_d = ena_i;
      end else if (ena_i && res_pass(f_ab_q)) begin
        en_d   = 1'b1;
        updn_d = (step_d == 2'd3);
      end
    end else if (init_q && (tmr_q == '0) && (s_ab_q == f_ab_q)) begin
      // Input settled at 00 since reset: nothing to adopt
      init_d = 1'b0;
    end
    sticky_d = err_d | (sticky_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 2'b00;
      s_ab_q   <= 2'b00;
      s_prev_q <= 2'b00;
      cnt_q    <= '0;
      f_ab_q   <= 2'b00;
      f_prev_q <= 2'b00;
      tmr_q    <= TW'(FILT_LEN + 1);
      init_q   <= 1'b1;
      en_q     <= 1'b0;
      updn_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync1_q  <= {a_i, b_i};
      s_ab_q   <= sync1_q;
      s_prev_q <= s_ab_q;
      cnt_q    <= cnt_d;
      f_ab_q   <= f_ab_d;
      f_prev_q <= f_ab_q;
      tmr_q    <= tmr_d;
      init_q   <= init_d;
      en_q     <= en_d;
      updn_q   <= updn_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign en_o         = en_q;
  assign updn_o       = updn_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: three resolutions side by side against a history-based model,
// with directed scenarios pinned by literal expectations followed by random A/B traffic.
`timescale 1ns/1ps
module tb_quad_decoder;
  localparam int F  = 3;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, ena = 1'b1, clr = 1'b0;
  logic [NR-1:0] en_w, updn_w, err_w, stk_w;

  int checks = 0;
  int failures = 0;

  always #100 clk = ~clk;

  quad_decoder #(.FILT_LEN(F), .RES(4)) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .ena_i(ena), .clr_err_i(clr),
    .en_o(en_w[0]), .updn_o(updn_w[0]), .err_o(err_w[0]), .err_sticky_o(stk_w[0]));
  quad_decoder #(.FILT_LEN(F), .RES(2)) dut_r2 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .ena_i(ena), .clr_err_i(clr),
    .en_o(en_w[1]), .updn_o(updn_w[1]), .err_o(err_w[1]), .err_sticky_o(stk_w[1]));
  quad_decoder #(.FILT_LEN(F), .RES(1)) dut_r1 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .ena_i(ena), .clr_err_i(clr),
    .en_o(en_w[2]), .updn_o(updn_w[2]), .err_o(err_w[2]), .err_sticky_o(stk_w[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int res_of(input int r);
    return (r == 0) ? 4 : (r == 1) ? 2 : 1;
  endfunction

  function automatic int gpos(input logic [1:0] ab);
    return (ab == 2'b00) ? 0 : (ab == 2'b10) ? 1 : (ab == 2'b11) ? 2 : 3;
  endfunction

  function automatic bit res_ok(input int res, input logic [1:0] n);
    return (res == 4) || (res == 2 && (n == 2'b00 || n == 2'b11)) || (n == 2'b00);
  endfunction

  // Model: raw samples per edge; the filter sees each sample two edges later and
  // accepts a value once it has been seen on FILT_LEN consecutive edges.
  logic [1:0] hq[$];
  logic [1:0] mf, mfp, mv;
  bit   minit, mev, magree;
  int   mk, md;
  bit   m_en[NR], m_up[NR], m_err[NR], m_stk[NR];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      hq.delete();
      for (int i = 0; i < F + 2; i++) hq.push_back(2'b00);
      mf = 2'b00; mfp = 2'b00; minit = 1'b1; mk = 0;
      for (int r = 0; r < NR; r++) begin
        m_en[r] = 0; m_up[r] = 0; m_err[r] = 0; m_stk[r] = 0;
      end
    end else begin
      mk++;
      hq.push_back({a, b});
      void'(hq.pop_front());
      mev = (mf != mfp);
      md  = (gpos(mf) - gpos(mfp) + 4) % 4;
      for (int r = 0; r < NR; r++) begin
        m_en[r] = 0; m_err[r] = 0;
      end
      if (mev) begin
        if (minit) minit = 1'b0;
        else for (int r = 0; r < NR; r++) begin
          if (md == 2) m_err[r] = ena;
          else if (ena && res_ok(res_of(r), mf)) begin
            m_en[r] = 1; m_up[r] = (md == 3);
          end
        end
      end else if (minit && mk >= F + 2 && hq[F-1] == mf) begin
        minit = 1'b0;
      end
      for (int r = 0; r < NR; r++) m_stk[r] = m_err[r] || (m_stk[r] && !clr);
      mv = hq[F-1];
      magree = 1'b1;
      for (int j = 0; j < F; j++) if (hq[j] != mv) magree = 1'b0;
      mfp = mf;
      if (magree && mv != mf) mf = mv;
    end
  end

  initial forever begin
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("model_en_res%0d", res_of(r)),   en_w[r],   m_en[r]);
      chk($sformatf("model_updn_res%0d", res_of(r)), updn_w[r], m_up[r]);
      chk($sformatf("model_err_res%0d", res_of(r)),  err_w[r],  m_err[r]);
      chk($sformatf("model_stk_res%0d", res_of(r)),  stk_w[r],  m_stk[r]);
    end
  end

  int c_en[NR];
  int c_err, first_en;

  task automatic clear_counts();
    for (int r = 0; r < NR; r++) c_en[r] = 0;
    c_err = 0;
    first_en = -1;
  endtask

  // Called at a negedge; holds AB for n edges, pulses clr_err before edge clr_at
  task automatic hold(input logic [1:0] ab, input int n, input int clr_at);
    {a, b} = ab;
    for (int i = 1; i <= n; i++) begin
      clr = (i == clr_at);
      @(posedge clk);
      @(negedge clk);
      for (int r = 0; r < NR; r++) if (en_w[r]) c_en[r]++;
      if (err_w[0]) c_err++;
      if (en_w[0] && first_en < 0) first_en = i;
    end
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {en_w, updn_w, err_w, stk_w}, 0);
    rst = 1'b0;

    clear_counts();
    hold(2'b00, 20, 0);
    chk("idle_en", c_en[0], 0);
    chk("idle_err", c_err, 0);
    chk("idle_outputs", {updn_w, stk_w}, 0);

    clear_counts();
    hold(2'b10, 10, 0);
    chk("up_latency", first_en, 6);
    hold(2'b11, 10, 0);
    hold(2'b01, 10, 0);
    hold(2'b00, 10, 0);
    chk("up_en_res4", c_en[0], 4);
    chk("up_en_res2", c_en[1], 2);
    chk("up_en_res1", c_en[2], 1);
    chk("up_err", c_err, 0);
    chk("up_updn", updn_w, 3'b000);

    clear_counts();
    hold(2'b01, 10, 0);
    hold(2'b11, 10, 0);
    hold(2'b10, 10, 0);
    hold(2'b00, 10, 0);
    chk("down_en_res4", c_en[0], 4);
    chk("down_en_res1", c_en[2], 1);
    chk("down_updn", updn_w, 3'b111);

    clear_counts();
    hold(2'b10, 2, 0);
    hold(2'b00, 10, 0);
    chk("glitch2_en", c_en[0], 0);
    clear_counts();
    hold(2'b10, 3, 0);
    hold(2'b00, 10, 0);
    chk("pulse3_en", c_en[0], 2);
    chk("pulse3_updn", updn_w[0], 1'b1);

    clear_counts();
    hold(2'b11, 10, 0);
    chk("double_err", c_err, 1);
    chk("double_en", c_en[0], 0);
    chk("double_sticky", stk_w, 3'b111);
    hold(2'b11, 3, 2);
    chk("clr_sticky", stk_w, 3'b000);
    clear_counts();
    hold(2'b00, 10, 6);
    chk("err_clr_err", c_err, 1);
    chk("err_clr_sticky", stk_w, 3'b111);

    ena = 1'b0;
    clear_counts();
    hold(2'b10, 10, 0);
    hold(2'b11, 10, 0);
    hold(2'b01, 10, 0);
    hold(2'b00, 10, 0);
    chk("ena0_en", c_en[0] + c_en[1] + c_en[2], 0);
    ena = 1'b1;

    hold(2'b11, 10, 0);
    #50 rst = 1'b1;
    #1 chk("async_reset_outputs", {en_w, updn_w, err_w, stk_w}, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    hold(2'b11, 20, 0);
    chk("init11_err", c_err, 0);
    chk("init11_en", c_en[0], 0);
    clear_counts();
    hold(2'b01, 10, 0);
    chk("init11_step_en", c_en[0], 1);
    chk("init11_step_updn", updn_w[0], 1'b0);

    for (int it = 0; it < 500; it++) begin
      int n;
      n = $urandom_range(1, 8);
      ena = ($urandom_range(0, 7) != 0);
      hold(2'($urandom_range(0, 3)), n, $urandom_range(0, 2 * n));
      if ($urandom_range(0, 59) == 0) begin
        #50 rst = 1'b1;
        #1 chk("rand_reset_outputs", {en_w, updn_w, err_w, stk_w}, 0);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
